// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the user-SRAM port arbiter.
// Owner ids are sized for the largest supported requester count.
package sram_arb_pkg;

   localparam int SRAM_ADDR_WD_DEF = 9;
   localparam int SRAM_DATA_WD_DEF = 32;
   localparam int SRAM_MASK_WD_DEF = SRAM_DATA_WD_DEF / 8;
   localparam int NREQ_MAX         = 4;
   localparam int REQ_ID_WD        = $clog2(NREQ_MAX);

   typedef logic [REQ_ID_WD-1:0] req_id_t;

   typedef struct packed {
      logic    vld;
      req_id_t id;
   } owner_t;

   function automatic logic [NREQ_MAX-1:0] id_to_onehot(input req_id_t id);
      logic [NREQ_MAX-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: the winner is the first requester at or after the pointer.
// The candidate is exposed independently of the enable so the parent can veto a grant.
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic         cand_vld,
   output req_id_t      cand_id,
   output logic [N-1:0] gnt
);

   req_id_t      ptr_r;
   logic [N-1:0] oh_s;

   // Scan from the pointer downwards so the nearest requester overrides farther ones.
   always_comb begin
      oh_s    = '0;
      cand_id = '0;
      for (int i = N - 1; i >= 0; i--) begin
         oh_s    = req[(int'(ptr_r) + i) % N] ? (N'(1'b1) << ((int'(ptr_r) + i) % N)) : oh_s;
         cand_id = req[(int'(ptr_r) + i) % N] ? req_id_t'((int'(ptr_r) + i) % N) : cand_id;
      end
   end

   assign cand_vld = |oh_s;
   assign gnt      = en ? oh_s : '0;

   // Pointer moves past the winner only when a grant is actually issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (|gnt) begin
         ptr_r <= (cand_id == req_id_t'(N - 1)) ? '0 : cand_id + req_id_t'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a read-only port A and write-only port B of the user SRAM among NREQ requesters,
// with registered pin drive and a fixed-latency, owner-tagged read return.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NREQ         = 2,
   parameter int SRAM_ADDR_WD = SRAM_ADDR_WD_DEF,
   parameter int SRAM_DATA_WD = SRAM_DATA_WD_DEF,
   parameter int READ_LAT     = 1
) (
   input  logic                             wb_clk_i,
   input  logic                             wb_rst_ni,
   input  logic                             arb_en_i,
   input  logic [NREQ-1:0]                  rd_req_i,
   input  logic [NREQ*SRAM_ADDR_WD-1:0]     rd_addr_i,
   output logic [NREQ-1:0]                  rd_gnt_o,
   output logic [NREQ-1:0]                  rd_valid_o,
   output logic [SRAM_DATA_WD-1:0]          rd_data_o,
   input  logic [NREQ-1:0]                  wr_req_i,
   input  logic [NREQ*SRAM_ADDR_WD-1:0]     wr_addr_i,
   input  logic [NREQ*SRAM_DATA_WD-1:0]     wr_data_i,
   input  logic [NREQ*SRAM_DATA_WD/8-1:0]   wr_mask_i,
   output logic [NREQ-1:0]                  wr_gnt_o,
   output logic                             busy_o,
   output logic                             sram_csb_a,
   output logic [SRAM_ADDR_WD-1:0]          sram_addr_a,
   input  logic [SRAM_DATA_WD-1:0]          sram_dout_a,
   output logic                             sram_csb_b,
   output logic                             sram_web_b,
   output logic [SRAM_DATA_WD/8-1:0]        sram_mask_b,
   output logic [SRAM_ADDR_WD-1:0]          sram_addr_b,
   output logic [SRAM_DATA_WD-1:0]          sram_din_b
);

   localparam int MASK_WD    = SRAM_DATA_WD / 8;
   localparam int PIPE_DEPTH = READ_LAT + 1;

   logic                    arb_ok_s;
   logic                    hazard_s;
   logic                    rd_en_s;
   logic                    rd_cand_vld_s;
   logic                    wr_cand_vld_s;
   req_id_t                 rd_cand_id_s;
   req_id_t                 wr_cand_id_s;
   logic [NREQ-1:0]         rd_gnt_s;
   logic [NREQ-1:0]         wr_gnt_s;
   logic [SRAM_ADDR_WD-1:0] rd_win_addr_s;
   logic [SRAM_ADDR_WD-1:0] wr_win_addr_s;
   logic [SRAM_DATA_WD-1:0] wr_win_data_s;
   logic [MASK_WD-1:0]      wr_win_mask_s;
   owner_t                  owner_pipe_r [PIPE_DEPTH];
   owner_t                  ret_owner_s;
   logic [NREQ_MAX-1:0]     ret_oh_s;
   logic [NREQ-1:0]         rd_valid_r;
   logic [SRAM_DATA_WD-1:0] rd_data_r;
   logic                    busy_s;

   assign arb_ok_s = arb_en_i & wb_rst_ni;

   assign rd_win_addr_s = rd_addr_i[rd_cand_id_s*SRAM_ADDR_WD +: SRAM_ADDR_WD];
   assign wr_win_addr_s = wr_addr_i[wr_cand_id_s*SRAM_ADDR_WD +: SRAM_ADDR_WD];
   assign wr_win_data_s = wr_data_i[wr_cand_id_s*SRAM_DATA_WD +: SRAM_DATA_WD];
   assign wr_win_mask_s = wr_mask_i[wr_cand_id_s*MASK_WD +: MASK_WD];

   // A read colliding with this cycle's write waits one cycle so it returns the new data.
   assign hazard_s = rd_cand_vld_s & wr_cand_vld_s & (rd_win_addr_s == wr_win_addr_s);
   assign rd_en_s  = arb_ok_s & ~hazard_s;

   rr_arbiter #(.N(NREQ)) u_rd_arb (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_ni),
      .req      (rd_req_i),
      .en       (rd_en_s),
      .cand_vld (rd_cand_vld_s),
      .cand_id  (rd_cand_id_s),
      .gnt      (rd_gnt_s)
   );

   rr_arbiter #(.N(NREQ)) u_wr_arb (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_ni),
      .req      (wr_req_i),
      .en       (arb_ok_s),
      .cand_vld (wr_cand_vld_s),
      .cand_id  (wr_cand_id_s),
      .gnt      (wr_gnt_s)
   );

   assign rd_gnt_o = rd_gnt_s;
   assign wr_gnt_o = wr_gnt_s;

   // Port B pins carry the winning write for exactly one cycle.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sram_csb_b  <= 1'b1;
         sram_web_b  <= 1'b1;
         sram_addr_b <= '0;
         sram_din_b  <= '0;
         sram_mask_b <= '0;
      end else if (|wr_gnt_s) begin
         sram_csb_b  <= 1'b0;
         sram_web_b  <= 1'b0;
         sram_addr_b <= wr_win_addr_s;
         sram_din_b  <= wr_win_data_s;
         sram_mask_b <= wr_win_mask_s;
      end else begin
         sram_csb_b  <= 1'b1;
         sram_web_b  <= 1'b1;
      end
   end

   // Port A pins carry the winning read address for exactly one cycle.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sram_csb_a  <= 1'b1;
         sram_addr_a <= '0;
      end else if (|rd_gnt_s) begin
         sram_csb_a  <= 1'b0;
         sram_addr_a <= rd_win_addr_s;
      end else begin
         sram_csb_a  <= 1'b1;
      end
   end

   // Owner tags travel alongside the SRAM access until its data is due.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            owner_pipe_r[i] <= '0;
         end
      end else begin
         owner_pipe_r[0].vld <= |rd_gnt_s;
         owner_pipe_r[0].id  <= rd_cand_id_s;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            owner_pipe_r[i] <= owner_pipe_r[i-1];
         end
      end
   end

   assign ret_owner_s = owner_pipe_r[PIPE_DEPTH-1];
   assign ret_oh_s    = id_to_onehot(ret_owner_s.id);

   // Capture SRAM data for the owner at the tail of the pipe; data holds between returns.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rd_valid_r <= '0;
         rd_data_r  <= '0;
      end else if (ret_owner_s.vld) begin
         rd_valid_r <= ret_oh_s[NREQ-1:0];
         rd_data_r  <= sram_dout_a;
      end else begin
         rd_valid_r <= '0;
      end
   end

   assign rd_valid_o = rd_valid_r;
   assign rd_data_o  = rd_data_r;

   // Busy while any read tag is still travelling.
   always_comb begin
      busy_s = 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         busy_s = busy_s | owner_pipe_r[i].vld;
      end
   end

   assign busy_o = busy_s;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter with an SRAM model, a reference
// arbitration/memory model and a scoreboard drained by an independent read-return monitor.
module tb_sram_port_arbiter;

   localparam int NREQ     = 2;
   localparam int AW       = 9;
   localparam int DW       = 32;
   localparam int MW       = DW / 8;
   localparam int READ_LAT = 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 arb_en = 1'b0;
   logic [NREQ-1:0]      rd_req = '0;
   logic [NREQ*AW-1:0]   rd_addr = '0;
   logic [NREQ-1:0]      rd_gnt_o;
   logic [NREQ-1:0]      rd_valid_o;
   logic [DW-1:0]        rd_data_o;
   logic [NREQ-1:0]      wr_req = '0;
   logic [NREQ*AW-1:0]   wr_addr = '0;
   logic [NREQ*DW-1:0]   wr_data = '0;
   logic [NREQ*MW-1:0]   wr_mask = '0;
   logic [NREQ-1:0]      wr_gnt_o;
   logic                 busy_o;
   logic                 sram_csb_a;
   logic [AW-1:0]        sram_addr_a;
   logic [DW-1:0]        sram_dout_a;
   logic                 sram_csb_b;
   logic                 sram_web_b;
   logic [MW-1:0]        sram_mask_b;
   logic [AW-1:0]        sram_addr_b;
   logic [DW-1:0]        sram_din_b;

   sram_port_arbiter #(
      .NREQ(NREQ), .SRAM_ADDR_WD(AW), .SRAM_DATA_WD(DW), .READ_LAT(READ_LAT)
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .arb_en_i(arb_en),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt_o),
      .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
      .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
      .wr_gnt_o(wr_gnt_o), .busy_o(busy_o),
      .sram_csb_a(sram_csb_a), .sram_addr_a(sram_addr_a), .sram_dout_a(sram_dout_a),
      .sram_csb_b(sram_csb_b), .sram_web_b(sram_web_b), .sram_mask_b(sram_mask_b),
      .sram_addr_b(sram_addr_b), .sram_din_b(sram_din_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM macro model: port A read with READ_LAT output latency, port B byte-masked write.
   bit [DW-1:0] mem [512];
   bit [DW-1:0] rd_pipe [READ_LAT];
   assign sram_dout_a = rd_pipe[READ_LAT-1];
   always @(posedge clk) begin
      if (!sram_csb_a) rd_pipe[0] <= mem[sram_addr_a];
      for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (!sram_csb_b && !sram_web_b)
         for (int b = 0; b < MW; b++)
            if (sram_mask_b[b]) mem[sram_addr_b][8*b +: 8] <= sram_din_b[8*b +: 8];
   end

   typedef struct {
      int            owner;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t            sb_q [$];
   bit [DW-1:0]     shadow [512];
   int              rd_ptr = 0;
   int              wr_ptr = 0;
   logic            exp_csb_a = 1'b1;
   logic            exp_csb_b = 1'b1;
   logic [AW-1:0]   exp_addr_a = '0;
   logic [AW-1:0]   exp_addr_b = '0;
   logic [DW-1:0]   exp_din_b = '0;
   logic [MW-1:0]   exp_mask_b = '0;
   logic [DW-1:0]   last_data = '0;
   logic [NREQ-1:0] seen_rd_gnt = '0;
   logic [NREQ-1:0] seen_wr_gnt = '0;
   int              n_tests = 0;
   int              n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NREQ-1:0] onehot(input int k);
      logic [NREQ-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Round-robin rule: first requesting index at or after ptr, modulo NREQ; -1 if none.
   function automatic int rr_pick(input logic [NREQ-1:0] req, input int ptr);
      for (int i = 0; i < NREQ; i++)
         if (req[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
      return -1;
   endfunction

   // One clock cycle: inputs already applied at the falling edge.
   task automatic do_cycle();
      int              ww;
      int              rw;
      int              wa;
      logic [DW-1:0]   wd;
      logic [MW-1:0]   wm;
      logic [NREQ-1:0] eg;
      logic            exp_busy;
      exp_t            e;
      #1;
      check("csb_a", sram_csb_a, exp_csb_a);
      if (!exp_csb_a) check("addr_a", sram_addr_a, exp_addr_a);
      check("csb_b", sram_csb_b, exp_csb_b);
      check("web_b", sram_web_b, exp_csb_b);
      if (!exp_csb_b)
         check("wr_pins", {sram_addr_b, sram_mask_b, sram_din_b}, {exp_addr_b, exp_mask_b, exp_din_b});
      exp_busy = 1'b0;
      foreach (sb_q[i])
         if (sb_q[i].due - (2 + READ_LAT) < cyc && cyc < sb_q[i].due) exp_busy = 1'b1;
      check("busy", busy_o, exp_busy);

      ww = arb_en ? rr_pick(wr_req, wr_ptr) : -1;
      rw = arb_en ? rr_pick(rd_req, rd_ptr) : -1;
      if (ww >= 0 && rw >= 0 && rd_addr[rw*AW +: AW] == wr_addr[ww*AW +: AW]) rw = -1;
      eg = (ww >= 0) ? onehot(ww) : '0;
      check("wr_gnt", wr_gnt_o, eg);
      eg = (rw >= 0) ? onehot(rw) : '0;
      check("rd_gnt", rd_gnt_o, eg);
      seen_rd_gnt = rd_gnt_o;
      seen_wr_gnt = wr_gnt_o;

      exp_csb_b = (ww < 0);
      if (ww >= 0) begin
         wa = int'(wr_addr[ww*AW +: AW]);
         wd = wr_data[ww*DW +: DW];
         wm = wr_mask[ww*MW +: MW];
         exp_addr_b = wr_addr[ww*AW +: AW];
         exp_din_b  = wd;
         exp_mask_b = wm;
         for (int b = 0; b < MW; b++)
            if (wm[b]) shadow[wa][8*b +: 8] = wd[8*b +: 8];
         wr_ptr = (ww + 1) % NREQ;
      end
      exp_csb_a = (rw < 0);
      if (rw >= 0) begin
         exp_addr_a = rd_addr[rw*AW +: AW];
         e.owner = rw;
         e.data  = shadow[int'(rd_addr[rw*AW +: AW])];
         e.due   = cyc + 2 + READ_LAT;
         sb_q.push_back(e);
         rd_ptr = (rw + 1) % NREQ;
      end
      @(negedge clk);
   endtask

   // Read-return monitor: every rd_valid_o pulse must match the oldest outstanding read.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rd_valid_o != '0) begin
            if (sb_q.size() == 0) begin
               check("rd_valid_spurious", rd_valid_o, 0);
            end else begin
               e = sb_q.pop_front();
               check("rd_owner", rd_valid_o, onehot(e.owner));
               check("rd_data", rd_data_o, e.data);
               check("rd_latency", cyc, e.due);
               last_data = e.data;
            end
         end else begin
            check("rd_data_hold", rd_data_o, last_data);
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
               e = sb_q.pop_front();
               check("rd_valid_missing", rd_valid_o, onehot(e.owner));
            end
         end
      end
   endtask

   task automatic idle(input int n);
      rd_req = '0;
      wr_req = '0;
      repeat (n) do_cycle();
   endtask

   task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
      wr_req              = onehot(k);
      wr_addr[k*AW +: AW] = a;
      wr_data[k*DW +: DW] = d;
      wr_mask[k*MW +: MW] = m;
   endtask

   initial begin
      logic [NREQ-1:0] rd_act;
      logic [NREQ-1:0] wr_act;
      rd_act = '0;
      wr_act = '0;

      repeat (3) @(negedge clk);
      #1;
      check("rst_gnt", {rd_gnt_o, wr_gnt_o}, 0);
      check("rst_valid", rd_valid_o, 0);
      check("rst_data", rd_data_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_ctrl", {sram_csb_a, sram_csb_b, sram_web_b}, 3'b111);
      check("rst_pins", {sram_addr_a, sram_addr_b, sram_din_b, sram_mask_b}, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      arb_en = 1'b1;
      fork
         monitor();
      join_none

      // Contention from reset: both read requesters held for six cycles.
      rd_addr = {9'h101, 9'h100};
      rd_req  = 2'b11;
      repeat (6) do_cycle();
      idle(4);

      // Single read of 0xDEADBEEF from address 0x05.
      set_wr(0, 9'h005, 32'hDEAD_BEEF, 4'hF);
      do_cycle();
      wr_req = '0;
      rd_req = 2'b01;
      rd_addr[0 +: AW] = 9'h005;
      do_cycle();
      idle(4);

      // Same-cycle read/write to 0x10: write first, read returns the new value.
      set_wr(0, 9'h010, 32'hA5A5_A5A5, 4'hF);
      rd_req = 2'b10;
      rd_addr[AW +: AW] = 9'h010;
      do_cycle();
      wr_req = '0;
      do_cycle();
      idle(4);

      // Byte-masked write over 0x11223344.
      set_wr(1, 9'h020, 32'h1122_3344, 4'hF);
      do_cycle();
      set_wr(0, 9'h020, 32'hFFFF_FFFF, 4'b0101);
      do_cycle();
      wr_req = '0;
      rd_req = 2'b01;
      rd_addr[0 +: AW] = 9'h020;
      do_cycle();
      idle(4);

      // Reset one cycle after a read grant: the read must never return.
      rd_req = 2'b01;
      rd_addr[0 +: AW] = 9'h005;
      do_cycle();
      rd_req = '0;
      #3;
      rst_n = 1'b0;
      last_data = '0;
      sb_q.delete();
      rd_ptr = 0;
      wr_ptr = 0;
      exp_csb_a = 1'b1;
      exp_csb_b = 1'b1;
      #1;
      check("rst_mid_csb_a", sram_csb_a, 1'b1);
      check("rst_mid_busy", busy_o, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("rst_mid_no_valid", rd_valid_o, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      // Disable arbitration with reads in flight: they still return, nothing new is granted.
      rd_addr = {9'h031, 9'h030};
      wr_addr = {9'h041, 9'h040};
      rd_req  = 2'b11;
      wr_req  = 2'b11;
      repeat (2) do_cycle();
      arb_en = 1'b0;
      repeat (6) do_cycle();
      arb_en = 1'b1;
      idle(3);

      // Randomized traffic over a small address window to provoke hazards.
      for (int c = 0; c < 800; c++) begin
         arb_en = ($urandom_range(0, 15) != 0);
         for (int k = 0; k < NREQ; k++) begin
            if (!rd_act[k]) begin
               if ($urandom_range(0, 1) == 1) begin
                  rd_act[k] = 1'b1;
                  rd_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
               end
            end else if ($urandom_range(0, 15) == 0) begin
               rd_act[k] = 1'b0;
            end
            if (!wr_act[k]) begin
               if ($urandom_range(0, 1) == 1) begin
                  wr_act[k] = 1'b1;
                  wr_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
                  wr_data[k*DW +: DW] = $urandom;
                  wr_mask[k*MW +: MW] = MW'($urandom_range(0, 15));
               end
            end else if ($urandom_range(0, 15) == 0) begin
               wr_act[k] = 1'b0;
            end
         end
         rd_req = rd_act;
         wr_req = wr_act;
         do_cycle();
         rd_act = rd_act & ~seen_rd_gnt;
         wr_act = wr_act & ~seen_wr_gnt;
      end
      idle(8);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
